vector_iir_decim: RTL and testbench
===================================

Name: vector_iir_decim

Overview:
- Per-bin exponential averager for streamed spectral vectors (e.g. FFT magnitude-squared output): y[n][k] = alpha*y[n-1][k] + beta*x[n][k].
- Has a built-in keep-one-in-N vector decimator, so a separate decimation stage is not needed.
- Sits in a computation engine between the FFT output stream and the downstream NoC shell.
- Generalised in data width, coefficient width and maximum vector length. Adds first-vector priming, tlast resync and an error flag.

Parameters:
- WIDTH, 32, unsigned sample width (input and output).
- COEFF_WIDTH, 16, unsigned Q0.COEFF_WIDTH coefficient width.
- MAX_LEN_LOG2, 10, log2 of maximum vector length; sets state RAM depth.
- SR_BASE, 8'd128, settings-bus base address.

Ports:
- ce_clk  in  1  clock
- ce_rst_n  in  1  synchronous active-low reset
- set_stb  in  1  settings write strobe
- set_addr  in  8  settings address
- set_data  in  32  settings data
- i_tdata  in  WIDTH  input sample
- i_tlast  in  1  input end of vector
- i_tvalid  in  1  input valid
- i_tready  out  1  input ready
- o_tdata  out  WIDTH  averaged sample
- o_tlast  out  1  last bin of output vector
- o_tvalid  out  1  output valid
- o_tready  in  1  output ready
- err_tlast  out  1  sticky: input tlast did not match vector_len

Behaviour:
- Reset is synchronous on ce_clk while ce_rst_n==0. Reset values:
  - o_tvalid=0, o_tlast=0, o_tdata=0, err_tlast=0, i_tready=0.
  - Bin index 0, vector counter 0, FSM=PRIME.
  - vector_len=16, alpha=0, beta=0, decim_n=1.
  - Reset asserted mid-vector discards in-flight data. RAM contents are don't-care, because PRIME overwrites them.
- Settings registers, each written when set_stb and set_addr matches:
  - SR_BASE+0: vector_len[MAX_LEN_LOG2:0]. Values <4 or >2^MAX_LEN_LOG2 are ignored (previous value kept).
  - SR_BASE+1: alpha[COEFF_WIDTH-1:0].
  - SR_BASE+2: beta[COEFF_WIDTH-1:0].
  - SR_BASE+3: decim_n[15:0]. The value 0 is treated as 1.
  - SR_BASE+4: write of any data requests a state clear.
- Shadow registers: all settings are captured into active registers only at a vector boundary (bin index 0, before the first sample of a vector is accepted). A change to vector_len or a state-clear request also forces FSM to PRIME and the vector counter to 0.
- FSM:
  - PRIME: y = x, written to RAM. Transitions to RUN after the last bin of the vector.
  - RUN: y = sat((alpha*y_prev + beta*x) >> COEFF_WIDTH). Truncation; saturate to 2^WIDTH-1.
  - Full product width is WIDTH+COEFF_WIDTH+1 bits before the shift.
- Pipeline:
  - 3 stages: RAM read / multiply / add-shift-saturate-writeback.
  - Latency is 3 cycles from input handshake to o_tvalid when o_tready is held high. Throughput is 1 sample/cycle.
  - Read-after-write hazard cannot occur because vector_len >= 4 exceeds the pipeline depth.
- Handshake:
  - The pipeline advances only when the output register is empty or being consumed. i_tready = advance.
  - When o_tready is low, every stage holds. No data is lost or duplicated.
  - o_tdata and o_tlast are stable while o_tvalid && !o_tready.
- Decimation:
  - The vector counter counts every completed input vector (including PRIME) and wraps at decim_n-1.
  - Only vectors with counter==decim_n-1 are emitted. Other vectors update RAM, are accepted at full rate, and produce o_tvalid=0.
- tlast:
  - o_tlast is generated on bin vector_len-1, independent of i_tlast.
  - If i_tlast arrives at bin < vector_len-1: set err_tlast, treat that sample as the vector's last, and restart bin index at 0.
  - If bin vector_len-1 arrives without i_tlast: set err_tlast and wrap the bin index anyway.
  - err_tlast is cleared only by reset or a state-clear write.
- Simultaneous set_stb and stream traffic is legal. The new value becomes active at the next boundary.

Optional Feature:
- Macro: VECTOR_IIR_DECIM_ROUND_EN.
  - Defined: add 2^(COEFF_WIDTH-1) before the right shift (round half up), then saturate.
  - Undefined: plain truncation. No extra adder is instantiated.

Test Plan:
- Steady state (COEFF_WIDTH=16): vector_len=8, alpha=0xE666, beta=0x1999, decim_n=1; constant x=1000, 3 vectors.
  - Vector 0 outputs 1000 in all bins (PRIME). Vector 1 outputs 999 (macro undefined) or 1000 (macro defined).
  - o_tlast on every 8th beat only.
- Decimation: decim_n=4, 12 input vectors of length 16.
  - Exactly 3 output vectors, corresponding to input vectors 3, 7, 11. Each has 16 beats with tlast on beat 15.
- Saturation: alpha=0xFFFF, beta=0xFFFF, x=0xFFFF_FFFF held for 2 vectors.
  - The second vector outputs 0xFFFF_FFFF with no wrap.
- Backpressure: random o_tready (50%) over 64 vectors of length 64.
  - Output sequence is identical to the o_tready=1 run. No beats lost or duplicated.
- tlast error: vector_len=8, i_tlast on beat 5.
  - err_tlast goes to 1. o_tlast is on the 6th beat of that vector. The next vector starts at bin 0.
  - A SR_BASE+4 write clears err_tlast and returns FSM to PRIME.
- Mid-vector config: write vector_len=32 at beat 3 of a 16-bin vector.
  - The current vector completes with 16 beats. The next vector is 32 bins and is primed (outputs equal inputs).

Source files
------------

// File: rtl/vector_iir_decim.sv
// vector_iir_decim: per-bin exponential averager y = sat((alpha*y_prev + beta*x) >> COEFF_WIDTH)
// with keep-one-in-N vector decimation. Define VECTOR_IIR_DECIM_ROUND_EN for round-half-up.
module vector_iir_decim #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned COEFF_WIDTH  = 16,
    parameter int unsigned MAX_LEN_LOG2 = 10,
    parameter logic [7:0]  SR_BASE      = 8'd128
) (
    input  logic             ce_clk,
    input  logic             ce_rst_n,
    input  logic             set_stb,
    input  logic [7:0]       set_addr,
    input  logic [31:0]      set_data,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic             err_tlast
);
    localparam int unsigned BW    = MAX_LEN_LOG2;
    localparam int unsigned LW    = MAX_LEN_LOG2 + 1;
    localparam int unsigned PW    = WIDTH + COEFF_WIDTH;
    localparam int unsigned SW    = PW + 1;
    localparam int unsigned DEPTH = 1 << MAX_LEN_LOG2;

    localparam logic [0:0]    ST_PRIME = 1'b0;
    localparam logic [0:0]    ST_RUN   = 1'b1;
    localparam logic [LW-1:0] LEN_RST  = LW'(16);
    localparam logic [31:0]   LEN_MIN  = 32'd4;
    localparam logic [31:0]   LEN_MAX  = 32'd1 << MAX_LEN_LOG2;

    // Drop the fractional bits and clamp to the largest representable sample.
    function automatic logic [WIDTH-1:0] sat_shift(input logic [SW-1:0] acc);
        logic [WIDTH:0] q;
        q = acc[SW-1:COEFF_WIDTH];
        if (q[WIDTH]) begin
            sat_shift = {WIDTH{1'b1}};
        end else begin
            sat_shift = q[WIDTH-1:0];
        end
    endfunction

    // Pending (bus-side) and active (stream-side) settings
    logic [LW-1:0]          len_p_q, len_p_d, len_q, len_d;
    logic [COEFF_WIDTH-1:0] alpha_p_q, alpha_p_d, alpha_q, alpha_d;
    logic [COEFF_WIDTH-1:0] beta_p_q, beta_p_d, beta_q, beta_d;
    logic [15:0]            decim_p_q, decim_p_d, decim_q, decim_d;
    logic                   clr_p_q, clr_p_d;

    logic [0:0]             fsm_q, fsm_d;
    logic [15:0]            vcnt_q, vcnt_d;
    logic [BW-1:0]          bin_q, bin_d;
    logic                   err_q, err_d;
    logic                   rdy_q;

    logic                   wr_len_s, wr_alpha_s, wr_beta_s, wr_decim_s, wr_clr_s;
    logic                   adv_s, accept_s, last_bin_s, end_s, emit_s, boundary_s, restart_s;

    logic                   s1_v_q, s1_emit_q, s1_last_q, s1_prime_q;
    logic [BW-1:0]          s1_bin_q;
    logic [WIDTH-1:0]       s1_x_q, rd_q;
    logic [COEFF_WIDTH-1:0] s1_alpha_q, s1_beta_q;

    logic                   s2_v_q, s2_emit_q, s2_last_q, s2_prime_q;
    logic [BW-1:0]          s2_bin_q;
    logic [WIDTH-1:0]       s2_x_q;
    logic [PW-1:0]          s2_pa_q, s2_pb_q;

    logic [SW-1:0]          sum_s;
    logic [WIDTH-1:0]       y_s;
    logic [WIDTH-1:0]       o_tdata_q;
    logic                   o_tlast_q, o_tvalid_q;

    logic [WIDTH-1:0]       ram_q [0:DEPTH-1];

    assign wr_len_s   = set_stb && (set_addr == SR_BASE) &&
                        (set_data >= LEN_MIN) && (set_data <= LEN_MAX);
    assign wr_alpha_s = set_stb && (set_addr == SR_BASE + 8'd1);
    assign wr_beta_s  = set_stb && (set_addr == SR_BASE + 8'd2);
    assign wr_decim_s = set_stb && (set_addr == SR_BASE + 8'd3);
    assign wr_clr_s   = set_stb && (set_addr == SR_BASE + 8'd4);

    // All stages move together; the output register gates everything.
    assign adv_s      = rdy_q && (!o_tvalid_q || o_tready);
    assign accept_s   = adv_s && i_tvalid;
    assign last_bin_s = ({1'b0, bin_q} == (len_q - LW'(1)));
    assign end_s      = last_bin_s || i_tlast;
    assign emit_s     = (vcnt_q >= (decim_q - 16'd1));
    assign boundary_s = accept_s ? end_s : (bin_q == {BW{1'b0}});
    assign restart_s  = boundary_s && (clr_p_q || (len_p_q != len_q));

    // Settings bus writes land in the pending set.
    always_comb begin
        len_p_d   = wr_len_s   ? set_data[LW-1:0]          : len_p_q;
        alpha_p_d = wr_alpha_s ? set_data[COEFF_WIDTH-1:0] : alpha_p_q;
        beta_p_d  = wr_beta_s  ? set_data[COEFF_WIDTH-1:0] : beta_p_q;
        decim_p_d = decim_p_q;
        if (wr_decim_s) begin
            decim_p_d = (set_data[15:0] == 16'd0) ? 16'd1 : set_data[15:0];
        end else begin
            decim_p_d = decim_p_q;
        end
        clr_p_d = clr_p_q;
        if (wr_clr_s) begin
            clr_p_d = 1'b1;
        end else if (boundary_s) begin
            clr_p_d = 1'b0;
        end else begin
            clr_p_d = clr_p_q;
        end
    end

    // Bin/vector bookkeeping, boundary capture of settings and the PRIME/RUN FSM.
    always_comb begin
        bin_d   = bin_q;
        fsm_d   = fsm_q;
        vcnt_d  = vcnt_q;
        len_d   = len_q;
        alpha_d = alpha_q;
        beta_d  = beta_q;
        decim_d = decim_q;
        err_d   = err_q;

        if (accept_s) begin
            bin_d = end_s ? {BW{1'b0}} : (bin_q + BW'(1));
        end else begin
            bin_d = bin_q;
        end

        if (boundary_s) begin
            len_d   = len_p_q;
            alpha_d = alpha_p_q;
            beta_d  = beta_p_q;
            decim_d = decim_p_q;
        end else begin
            len_d   = len_q;
            alpha_d = alpha_q;
            beta_d  = beta_q;
            decim_d = decim_q;
        end

        if (restart_s) begin
            fsm_d  = ST_PRIME;
            vcnt_d = 16'd0;
        end else if (accept_s && end_s) begin
            case (fsm_q)
                ST_PRIME: fsm_d = ST_RUN;
                ST_RUN:   fsm_d = ST_RUN;
                default:  fsm_d = ST_PRIME;
            endcase
            vcnt_d = emit_s ? 16'd0 : (vcnt_q + 16'd1);
        end else begin
            fsm_d  = fsm_q;
            vcnt_d = vcnt_q;
        end

        if (wr_clr_s) begin
            err_d = 1'b0;
        end else if (accept_s && (i_tlast != last_bin_s)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Control and settings state.
    always_ff @(posedge ce_clk) begin
        if (!ce_rst_n) begin
            len_p_q   <= LEN_RST;
            alpha_p_q <= {COEFF_WIDTH{1'b0}};
            beta_p_q  <= {COEFF_WIDTH{1'b0}};
            decim_p_q <= 16'd1;
            clr_p_q   <= 1'b0;
            len_q     <= LEN_RST;
            alpha_q   <= {COEFF_WIDTH{1'b0}};
            beta_q    <= {COEFF_WIDTH{1'b0}};
            decim_q   <= 16'd1;
            fsm_q     <= ST_PRIME;
            vcnt_q    <= 16'd0;
            bin_q     <= {BW{1'b0}};
            err_q     <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            len_p_q   <= len_p_d;
            alpha_p_q <= alpha_p_d;
            beta_p_q  <= beta_p_d;
            decim_p_q <= decim_p_d;
            clr_p_q   <= clr_p_d;
            len_q     <= len_d;
            alpha_q   <= alpha_d;
            beta_q    <= beta_d;
            decim_q   <= decim_d;
            fsm_q     <= fsm_d;
            vcnt_q    <= vcnt_d;
            bin_q     <= bin_d;
            err_q     <= err_d;
            rdy_q     <= 1'b1;
        end
    end

`ifdef VECTOR_IIR_DECIM_ROUND_EN
    localparam logic [SW-1:0] ROUND_C = SW'(1) << (COEFF_WIDTH - 1);
    assign sum_s = {1'b0, s2_pa_q} + {1'b0, s2_pb_q} + ROUND_C;
`else
    assign sum_s = {1'b0, s2_pa_q} + {1'b0, s2_pb_q};
`endif

    assign y_s = s2_prime_q ? s2_x_q : sat_shift(sum_s);

    // Stage 1 (capture + RAM read), stage 2 (multiply), stage 3 (output register).
    always_ff @(posedge ce_clk) begin
        if (!ce_rst_n) begin
            s1_v_q     <= 1'b0;
            s1_emit_q  <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_prime_q <= 1'b0;
            s1_bin_q   <= {BW{1'b0}};
            s1_x_q     <= {WIDTH{1'b0}};
            s1_alpha_q <= {COEFF_WIDTH{1'b0}};
            s1_beta_q  <= {COEFF_WIDTH{1'b0}};
            s2_v_q     <= 1'b0;
            s2_emit_q  <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_prime_q <= 1'b0;
            s2_bin_q   <= {BW{1'b0}};
            s2_x_q     <= {WIDTH{1'b0}};
            s2_pa_q    <= {PW{1'b0}};
            s2_pb_q    <= {PW{1'b0}};
            o_tdata_q  <= {WIDTH{1'b0}};
            o_tlast_q  <= 1'b0;
            o_tvalid_q <= 1'b0;
        end else if (adv_s) begin
            s1_v_q     <= accept_s;
            s1_emit_q  <= emit_s;
            s1_last_q  <= end_s;
            s1_prime_q <= (fsm_q == ST_PRIME);
            s1_bin_q   <= bin_q;
            s1_x_q     <= i_tdata;
            s1_alpha_q <= alpha_q;
            s1_beta_q  <= beta_q;
            s2_v_q     <= s1_v_q;
            s2_emit_q  <= s1_emit_q;
            s2_last_q  <= s1_last_q;
            s2_prime_q <= s1_prime_q;
            s2_bin_q   <= s1_bin_q;
            s2_x_q     <= s1_x_q;
            s2_pa_q    <= PW'(s1_alpha_q) * PW'(rd_q);
            s2_pb_q    <= PW'(s1_beta_q) * PW'(s1_x_q);
            o_tvalid_q <= s2_v_q && s2_emit_q;
            o_tlast_q  <= s2_v_q && s2_emit_q && s2_last_q;
            if (s2_v_q && s2_emit_q) begin
                o_tdata_q <= y_s;
            end
        end
    end

    // State RAM: read lines up with stage 1, write-back from stage 3; contents are not reset.
    always_ff @(posedge ce_clk) begin
        if (adv_s) begin
            rd_q <= ram_q[bin_q];
            if (s2_v_q) begin
                ram_q[s2_bin_q] <= y_s;
            end
        end
    end

    assign i_tready  = adv_s;
    assign o_tdata   = o_tdata_q;
    assign o_tlast   = o_tlast_q;
    assign o_tvalid  = o_tvalid_q;
    assign err_tlast = err_q;

endmodule

// File: tb/tb_vector_iir_decim.sv
// Self-checking bench for vector_iir_decim: directed table, vector-level reference model,
// and hand-written tlast-error / mid-vector-config sequences.
module tb_vector_iir_decim;
    logic        ce_clk = 1'b0;
    logic        ce_rst_n = 1'b0;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = 8'd0;
    logic [31:0] set_data = 32'd0;
    logic [31:0] i_tdata = 32'd0;
    logic        i_tlast = 1'b0;
    logic        i_tvalid = 1'b0;
    logic        i_tready;
    logic [31:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready = 1'b1;
    logic        err_tlast;

    int n_checks = 0;
    int n_fail = 0;
    bit bp_en = 1'b0;

`ifdef VECTOR_IIR_DECIM_ROUND_EN
    localparam longint unsigned RND = 64'd32768;
`else
    localparam longint unsigned RND = 64'd0;
`endif

    typedef struct packed { logic [31:0] d; logic l; } beat_t;
    beat_t got_q[$];
    beat_t exp_q[$];
    logic [31:0] vec_buf [0:1023];

    // Model state: one stored average per bin plus prime flag and vector counter.
    longint unsigned m_y [0:1023];
    bit              m_prime;
    int              m_vcnt, m_decim, m_len;
    longint unsigned m_alpha, m_beta;

    vector_iir_decim dut (
        .ce_clk(ce_clk), .ce_rst_n(ce_rst_n),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .err_tlast(err_tlast)
    );

    always #5 ce_clk = ~ce_clk;

    always @(posedge ce_clk) begin
        #1;
        o_tready = bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    always @(negedge ce_clk) begin
        if (ce_rst_n && o_tvalid && o_tready) got_q.push_back({o_tdata, o_tlast});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, act, expv);
        end
    endtask

    task automatic compare_q(input string name);
        check({name, "_count"}, 0, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check(name, i, 64'(got_q[i]), 64'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic sr_write(input logic [7:0] off, input logic [31:0] d);
        set_stb = 1'b1; set_addr = 8'd128 + off; set_data = d;
        @(posedge ce_clk); #1;
        set_stb = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge ce_clk);
        #1;
    endtask

    task automatic drain();
        bp_en = 1'b0;
        idle(12);
    endtask

    task automatic model_reset();
        m_prime = 1'b1; m_vcnt = 0; m_decim = 1; m_len = 16; m_alpha = 0; m_beta = 0;
    endtask

    task automatic cfg(input int len, input int a, input int b, input int dec, input bit clr);
        sr_write(8'd0, 32'(len));
        sr_write(8'd1, 32'(a));
        sr_write(8'd2, 32'(b));
        sr_write(8'd3, 32'(dec));
        if (clr) sr_write(8'd4, 32'd0);
        idle(3);
        if (clr || len != m_len) begin m_prime = 1'b1; m_vcnt = 0; end
        m_len = len; m_alpha = longint'(a); m_beta = longint'(b);
        m_decim = (dec == 0) ? 1 : dec;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic l);
        bit acc;
        int guard;
        i_tdata = d; i_tlast = l; i_tvalid = 1'b1;
        acc = 1'b0; guard = 0;
        while (!acc && guard < 200) begin
            @(negedge ce_clk);
            acc = i_tready;
            @(posedge ce_clk); #1;
            guard++;
        end
        i_tvalid = 1'b0; i_tlast = 1'b0;
        if (!acc) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: i_tready stayed 0 for %0d cycles", guard);
        end
    endtask

    task automatic send_vector(input int len, input int tlast_pos);
        for (int k = 0; k < len; k++) send_beat(vec_buf[k], k == tlast_pos);
    endtask

    task automatic fill_rand(input int len);
        for (int k = 0; k < len; k++) vec_buf[k] = $urandom;
    endtask

    task automatic fill_const(input int len, input logic [31:0] v);
        for (int k = 0; k < len; k++) vec_buf[k] = v;
    endtask

    // One whole input vector through the averaging rule, then decimation decision.
    task automatic model_vector(input int len);
        for (int k = 0; k < len; k++) begin
            longint unsigned x, y;
            beat_t b;
            x = longint'(vec_buf[k]);
            if (m_prime) y = x;
            else begin
                y = (m_alpha * m_y[k] + m_beta * x + RND) >> 16;
                if (y > 64'hFFFF_FFFF) y = 64'hFFFF_FFFF;
            end
            m_y[k] = y;
            b.d = y[31:0];
            b.l = (k == len - 1);
            if (m_vcnt == m_decim - 1) exp_q.push_back(b);
        end
        m_prime = 1'b0;
        m_vcnt = (m_vcnt + 1) % m_decim;
    endtask

    // Expected output for alpha=0, beta=0x8000 (half of x, independent of history).
    function automatic beat_t half_beat(input logic [31:0] x, input logic l);
        longint unsigned y;
        beat_t b;
        y = (64'd32768 * longint'(x) + RND) >> 16;
        b.d = y[31:0];
        b.l = l;
        return b;
    endfunction

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] x;
        logic [31:0] y_trunc;
        logic [31:0] y_round;
    } tv_t;
    tv_t tbl [6];

    initial begin
        beat_t bt;
        tbl[0] = '{16'hE666, 16'h1999, 32'd1000,        32'd999,         32'd1000};
        tbl[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFF_FFFF,   32'hFFFF_FFFF,   32'hFFFF_FFFF};
        tbl[2] = '{16'h8000, 16'h8000, 32'd100,         32'd100,         32'd100};
        tbl[3] = '{16'h0000, 16'h0000, 32'd12345,       32'd0,           32'd0};
        tbl[4] = '{16'h4000, 16'h4000, 32'd3,           32'd1,           32'd2};
        tbl[5] = '{16'h0000, 16'hFFFF, 32'hFFFF_FFFF,   32'hFFFE_FFFF,   32'hFFFE_FFFF};

        // Reset state
        repeat (3) @(posedge ce_clk);
        @(negedge ce_clk);
        check("rst_i_tready", 0, 64'(i_tready), 64'd0);
        check("rst_o_tvalid", 0, 64'(o_tvalid), 64'd0);
        check("rst_o_tlast", 0, 64'(o_tlast), 64'd0);
        check("rst_o_tdata", 0, 64'(o_tdata), 64'd0);
        check("rst_err_tlast", 0, 64'(err_tlast), 64'd0);
        @(posedge ce_clk); #1;
        ce_rst_n = 1'b1;
        idle(2);
        @(negedge ce_clk);
        check("post_rst_i_tready", 0, 64'(i_tready), 64'd1);
        @(posedge ce_clk); #1;

        // Default settings: 16-bin primed vector passes inputs through
        model_reset();
        fill_rand(16);
        send_vector(16, 15);
        model_vector(16);
        drain();
        compare_q("default_prime");

        // Directed coefficient table: prime vector then one run vector of length 4
        for (int t = 0; t < 6; t++) begin
            cfg(4, int'(tbl[t].a), int'(tbl[t].b), 1, 1'b1);
            fill_const(4, tbl[t].x);
            send_vector(4, 3);
            send_vector(4, 3);
            drain();
            for (int k = 0; k < 8; k++) begin
                bt.d = (k < 4) ? tbl[t].x : ((RND != 0) ? tbl[t].y_round : tbl[t].y_trunc);
                bt.l = (k % 4 == 3);
                exp_q.push_back(bt);
            end
            compare_q("table");
        end

        // Steady state, three vectors of constant 1000
        cfg(8, 16'hE666, 16'h1999, 1, 1'b1);
        fill_const(8, 32'd1000);
        for (int v = 0; v < 3; v++) begin send_vector(8, 7); model_vector(8); end
        drain();
        if (got_q.size() > 8)
            check("steady_v1_bin0", 0, 64'(got_q[8].d), (RND != 0) ? 64'd1000 : 64'd999);
        else
            check("steady_count", 0, 64'(got_q.size()), 64'd24);
        compare_q("steady");

        // Decimation by 4 over 12 vectors of 16
        cfg(16, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), 4, 1'b1);
        for (int v = 0; v < 12; v++) begin fill_rand(16); send_vector(16, 15); model_vector(16); end
        drain();
        check("decim_beats", 0, 64'(got_q.size()), 64'd48);
        compare_q("decim");

        // Backpressure: 64 vectors of 64 with random o_tready, decim written as 0
        cfg(64, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), 0, 1'b1);
        bp_en = 1'b1;
        for (int v = 0; v < 64; v++) begin fill_rand(64); send_vector(64, 63); model_vector(64); end
        drain();
        compare_q("backpressure");

        // Early tlast: 6-beat primed vector, then a full run vector
        cfg(8, 0, 16'h8000, 1, 1'b1);
        check("err_after_clear", 0, 64'(err_tlast), 64'd0);
        fill_rand(8);
        send_vector(6, 5);
        for (int k = 0; k < 6; k++) begin bt.d = vec_buf[k]; bt.l = (k == 5); exp_q.push_back(bt); end
        idle(1);
        check("err_early_tlast", 0, 64'(err_tlast), 64'd1);
        fill_rand(8);
        send_vector(8, 7);
        for (int k = 0; k < 8; k++) exp_q.push_back(half_beat(vec_buf[k], k == 7));
        drain();
        compare_q("early_tlast");
        check("err_sticky", 0, 64'(err_tlast), 64'd1);
        sr_write(8'd4, 32'd0);
        check("err_cleared", 0, 64'(err_tlast), 64'd0);
        idle(3);
        fill_rand(8);
        send_vector(8, 7);
        for (int k = 0; k < 8; k++) begin bt.d = vec_buf[k]; bt.l = (k == 7); exp_q.push_back(bt); end
        drain();
        compare_q("reprime_after_clear");
        // Missing tlast on the last bin: wraps anyway and flags
        fill_rand(8);
        send_vector(8, -1);
        for (int k = 0; k < 8; k++) exp_q.push_back(half_beat(vec_buf[k], k == 7));
        idle(1);
        check("err_missing_tlast", 0, 64'(err_tlast), 64'd1);
        fill_rand(8);
        send_vector(8, 7);
        for (int k = 0; k < 8; k++) exp_q.push_back(half_beat(vec_buf[k], k == 7));
        drain();
        compare_q("missing_tlast");

        // Mid-vector length change takes effect at the next boundary with re-prime
        cfg(16, 0, 16'h8000, 1, 1'b1);
        fill_rand(16);
        send_vector(16, 15);
        for (int k = 0; k < 16; k++) begin bt.d = vec_buf[k]; bt.l = (k == 15); exp_q.push_back(bt); end
        fill_rand(16);
        for (int k = 0; k < 16; k++) begin
            if (k == 3) begin set_stb = 1'b1; set_addr = 8'd128; set_data = 32'd32; end
            send_beat(vec_buf[k], k == 15);
            set_stb = 1'b0;
            exp_q.push_back(half_beat(vec_buf[k], k == 15));
        end
        fill_rand(32);
        send_vector(32, 31);
        for (int k = 0; k < 32; k++) begin bt.d = vec_buf[k]; bt.l = (k == 31); exp_q.push_back(bt); end
        // Out-of-range lengths are ignored
        sr_write(8'd0, 32'd3);
        sr_write(8'd0, 32'd1025);
        idle(3);
        fill_rand(32);
        send_vector(32, 31);
        for (int k = 0; k < 32; k++) exp_q.push_back(half_beat(vec_buf[k], k == 31));
        drain();
        compare_q("mid_vector_cfg");
        check("err_mid_cfg", 0, 64'(err_tlast), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
